// File: rtl/pgm_multi.sv
// pgm_multi: N-player card-game controller. Deals an initial card to every
// player, then runs hit rounds driven by the MORE draw mask until at most
// one player survives or nobody asks for a card, and reports the winner.
// Every card is streamed on OUT_VALID/PLAYER/CARD. The game result appears
// on END_VALID/WIN/SUM. After the result the block returns to idle.
// Optional feature: define PGM_DEALER_EN to make player NPLAYER-1 a dealer
// that draws automatically up to DEALER_STAND before the result.
module pgm_multi #(
  parameter int          NPLAYER      = 3,
  parameter int          MAXH         = 10,
  parameter int          CARD_MAX     = 8,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          DEALER_STAND = 7,
  localparam int         HW           = $clog2(MAXH + CARD_MAX + 1)
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               IN_VALID,
  input  logic               BUTTON,
  input  logic [NPLAYER-1:0] MORE,
  output logic               OUT_VALID,
  output logic [1:0]         PLAYER,
  output logic [3:0]         CARD,
  output logic               END_VALID,
  output logic [2:0]         WIN,
  output logic [HW-1:0]      SUM
);

  localparam logic [HW-1:0] MAXH_W  = HW'(MAXH);
  localparam logic [HW-1:0] STAND_W = HW'(DEALER_STAND);
  localparam logic [2:0]    NO_WIN  = 3'(NPLAYER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAL,
    S_CHECK,
    S_WAIT,
    S_HIT,
    S_END,
`ifdef PGM_DEALER_EN
    S_DEALER,
`endif
    S_RESULT
  } state_t;

  logic               in_valid_q, button_q, button_prev_q;
  logic [NPLAYER-1:0] more_q;
  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [NPLAYER-1:0] mask_q, mask_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [HW-1:0]      hand_q [NPLAYER];
  logic [HW-1:0]      hand_d [NPLAYER];
  logic               out_valid_q, out_valid_d;
  logic [1:0]         player_q, player_d;
  logic [3:0]         card_q, card_d;
  logic               end_valid_q, end_valid_d;
  logic [2:0]         win_q, win_d;
  logic [HW-1:0]      sum_q, sum_d;

  logic               cmd;
  logic [3:0]         card_val;
  logic [NPLAYER-1:0] busted, eff_mask, low_src, low_bit;
  logic [1:0]         low_idx, deal_idx;
  logic               deal_en;
  logic [2:0]         n_alive, win_idx;
  logic [HW-1:0]      best;
  logic               found, tie;

  // A command is a fresh rising edge of the registered button while valid.
  assign cmd = in_valid_q & button_q & ~button_prev_q;

  // Galois LFSR (taps 16,14,13,11) free-runs; card is drawn from its state.
  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    card_val = 4'(lfsr_q % 16'(CARD_MAX)) + 4'd1;
  end

  // Per-player bust flags, survivor count and the effective draw mask.
  always_comb begin
    n_alive = '0;
    for (int i = 0; i < NPLAYER; i++) begin
      busted[i] = hand_q[i] > MAXH_W;
      if (!busted[i]) n_alive = n_alive + 3'd1;
    end
    eff_mask = more_q & ~busted;
`ifdef PGM_DEALER_EN
    eff_mask[NPLAYER-1] = 1'b0;
`endif
  end

  // Lowest pending player of the hit mask (fresh mask in WAIT, latched in HIT).
  always_comb begin
    low_src = (state_q == S_WAIT) ? eff_mask : mask_q;
    low_idx = '0;
    for (int i = NPLAYER - 1; i >= 0; i--) begin
      if (low_src[i]) low_idx = 2'(i);
    end
    low_bit = NPLAYER'(1) << low_idx;
  end

  // Unique highest hand among surviving players; ties or no survivor -> none.
  always_comb begin
    best    = '0;
    win_idx = NO_WIN;
    found   = 1'b0;
    tie     = 1'b0;
    for (int i = 0; i < NPLAYER; i++) begin
      if (!busted[i]) begin
        if (!found || hand_q[i] > best) begin
          best    = hand_q[i];
          win_idx = 3'(i);
          found   = 1'b1;
          tie     = 1'b0;
        end else if (hand_q[i] == best) begin
          tie = 1'b1;
        end
      end
    end
    if (!found || tie) begin
      best    = '0;
      win_idx = NO_WIN;
    end
  end

  // Next-state logic; a card is dealt on every edge that enters or stays in a
  // dealing state, so each card is visible while the FSM sits in that state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    mask_d   = mask_q;
    deal_en  = 1'b0;
    deal_idx = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd) begin
          state_d = S_DEAL;
          deal_en = 1'b1;
          ptr_d   = 3'd1;
        end
      end
      S_DEAL: begin
        if (ptr_q == 3'(NPLAYER)) begin
          state_d = S_CHECK;
        end else begin
          deal_en  = 1'b1;
          deal_idx = ptr_q[1:0];
          ptr_d    = ptr_q + 3'd1;
        end
      end
      S_CHECK: state_d = (n_alive <= 3'd1) ? S_RESULT : S_WAIT;
      S_WAIT: begin
        if (cmd) begin
          if (eff_mask == '0) begin
            state_d = S_END;
          end else begin
            state_d  = S_HIT;
            deal_en  = 1'b1;
            deal_idx = low_idx;
            mask_d   = eff_mask & ~low_bit;
          end
        end
      end
      S_HIT: begin
        if (mask_q == '0) begin
          state_d = S_CHECK;
        end else begin
          deal_en  = 1'b1;
          deal_idx = low_idx;
          mask_d   = mask_q & ~low_bit;
        end
      end
`ifdef PGM_DEALER_EN
      S_END:    state_d = S_DEALER;
      S_DEALER: begin
        if (!busted[NPLAYER-1] && hand_q[NPLAYER-1] < STAND_W) begin
          deal_en  = 1'b1;
          deal_idx = 2'(NPLAYER - 1);
        end else begin
          state_d = S_RESULT;
        end
      end
`else
      S_END:    state_d = S_RESULT;
`endif
      S_RESULT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Hand updates, card stream and result registers.
  always_comb begin
    for (int i = 0; i < NPLAYER; i++) begin
      hand_d[i] = hand_q[i];
      if (state_d == S_IDLE) begin
        hand_d[i] = '0;
      end else if (deal_en && deal_idx == 2'(i)) begin
        hand_d[i] = hand_q[i] + HW'(card_val);
      end
    end
    out_valid_d = deal_en;
    player_d    = deal_en ? deal_idx : player_q;
    card_d      = deal_en ? card_val : 4'd0;
    end_valid_d = (state_d == S_RESULT);
    win_d       = end_valid_d ? win_idx : win_q;
    sum_d       = end_valid_d ? best : sum_q;
  end

  // State and datapath registers; reset takes effect at once, even mid-game.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_valid_q    <= 1'b0;
      button_q      <= 1'b0;
      button_prev_q <= 1'b0;
      more_q        <= '0;
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      mask_q        <= '0;
      lfsr_q        <= SEED;
      // NOTE: the hands are a handful of flops, not a RAM, so they take reset
      // like any other state and a reset mid-game leaves no stale score.
      for (int i = 0; i < NPLAYER; i++) hand_q[i] <= '0;
      out_valid_q   <= 1'b0;
      player_q      <= '0;
      card_q        <= '0;
      end_valid_q   <= 1'b0;
      win_q         <= NO_WIN;
      sum_q         <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // so the order of these lines does not matter.
      in_valid_q    <= IN_VALID;
      button_q      <= BUTTON;
      button_prev_q <= button_q;
      more_q        <= MORE;
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      mask_q        <= mask_d;
      lfsr_q        <= lfsr_d;
      for (int i = 0; i < NPLAYER; i++) hand_q[i] <= hand_d[i];
      out_valid_q   <= out_valid_d;
      player_q      <= player_d;
      card_q        <= card_d;
      end_valid_q   <= end_valid_d;
      win_q         <= win_d;
      sum_q         <= sum_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign PLAYER    = player_q;
  assign CARD      = card_q;
  assign END_VALID = end_valid_q;
  assign WIN       = win_q;
  assign SUM       = sum_q;

endmodule
